// File: rtl/otsu_mem_responder_pkg.sv
// Shared types and constants for the otsu memory responder.
// Imported by the interface, the pixel RAM and the responder top.
package otsu_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } otsu_mem_state_t;

  localparam logic [31:0] OTSU_OUT_BASE = 32'h0010_0000;
  localparam logic [7:0]  OTSU_OOB_DATA = 8'hFF;

  // Number of packed binary output bytes for a w x h image.
  function automatic int unsigned otsu_nout(input int unsigned w, input int unsigned h);
    return (w * h) / 32'd8;
  endfunction

endpackage

// File: rtl/otsu_mem_responder_if.sv
// Bundle of the memory initiator bus, host load port, drain port and status flags.
// The master side is otsu_top plus host and drain consumer; the slave side is the responder.
interface otsu_mem_responder_if;
  import otsu_pkg::*;

  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        processing_done;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        image_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic        err_oob_rd;
  logic        err_bad_wr;

  modport master (
    output mem_en, mem_rw, mem_addr, mem_data_out, processing_done,
    output load_valid, load_data, rd_ready,
    input  mem_data_in, load_ready, image_ready, rd_valid, rd_data,
    input  err_oob_rd, err_bad_wr
  );

  modport slave (
    input  mem_en, mem_rw, mem_addr, mem_data_out, processing_done,
    input  load_valid, load_data, rd_ready,
    output mem_data_in, load_ready, image_ready, rd_valid, rd_data,
    output err_oob_rd, err_bad_wr
  );

endinterface

// File: rtl/otsu_mem_responder_pix_ram.sv
// Image storage: one synchronous write port for loading and one registered read port.
// The read register holds its value between reads and clears on reset.
module otsu_pix_ram
  import otsu_pkg::*;
#(
  parameter int unsigned NPIX = 64,
  parameter int unsigned AW   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [NPIX];
  logic [7:0] rdata_d;
  logic [7:0] rdata_q;

  // Pixel array write; contents are deliberately not cleared on reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data selection: capture on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/otsu_mem_responder.sv
// Memory responder beside otsu_top: holds the image, captures the packed output bytes,
// and streams them out over a valid/ready drain port once processing is done.
module otsu_mem_responder
  import otsu_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 8,
  parameter int unsigned IMAGE_HEIGHT = 8,
  parameter logic [31:0] OUT_BASE     = OTSU_OUT_BASE,
  parameter logic [7:0]  OOB_DATA     = OTSU_OOB_DATA
) (
  input logic                  clk,
  input logic                  reset,
  otsu_mem_responder_if.slave  bus
);

  localparam int unsigned NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned NOUT = otsu_nout(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int unsigned LW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned DW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [31:0] NPIX_ADDR = 32'(NPIX);
  localparam logic [31:0] NOUT_LEN  = 32'(NOUT);

  otsu_mem_state_t state_q, state_d;
  logic [LW-1:0]   load_idx_q, load_idx_d;
  logic [DW-1:0]   drain_idx_q, drain_idx_d;
  logic [7:0]      out_buf_q [NOUT];
  logic [7:0]      out_buf_d [NOUT];
  logic            rd_oob_q, rd_oob_d;
  logic            err_oob_rd_q, err_oob_rd_d;
  logic            err_bad_wr_q, err_bad_wr_d;
  logic            load_ready_q, load_ready_d;
  logic            image_ready_q, image_ready_d;
  logic            rd_valid_q, rd_valid_d;

  logic            rd_req_s, wr_req_s, rd_hit_s, wr_hit_s;
  logic            load_fire_s, drain_fire_s;
  logic [31:0]     wr_off_s;
  logic [7:0]      ram_rdata_s;

  // Address decode over the full 32-bit address; the offset form avoids overflow at the top.
  always_comb begin
    rd_req_s     = bus.mem_en && !bus.mem_rw;
    wr_req_s     = bus.mem_en && bus.mem_rw;
    rd_hit_s     = (state_q != LOAD) && (bus.mem_addr < NPIX_ADDR);
    wr_off_s     = bus.mem_addr - OUT_BASE;
    wr_hit_s     = (state_q == SERVE) && (bus.mem_addr >= OUT_BASE) && (wr_off_s < NOUT_LEN);
    load_fire_s  = (state_q == LOAD) && bus.load_valid;
    drain_fire_s = (state_q == DRAIN) && bus.rd_ready;
  end

  otsu_pix_ram #(
    .NPIX (NPIX),
    .AW   (LW)
  ) u_pix_ram (
    .clk   (clk),
    .reset (reset),
    .we    (load_fire_s),
    .waddr (load_idx_q),
    .wdata (bus.load_data),
    .re    (rd_req_s && rd_hit_s),
    .raddr (bus.mem_addr[LW-1:0]),
    .rdata (ram_rdata_s)
  );

  // Next-state, buffer update and sticky flag logic.
  always_comb begin
    state_d       = state_q;
    load_idx_d    = load_idx_q;
    drain_idx_d   = drain_idx_q;
    out_buf_d     = out_buf_q;
    rd_oob_d      = rd_oob_q;
    err_oob_rd_d  = err_oob_rd_q;
    err_bad_wr_d  = err_bad_wr_q;

    if (rd_req_s) begin
      rd_oob_d = !rd_hit_s;
      if (!rd_hit_s) begin
        err_oob_rd_d = 1'b1;
      end else begin
        err_oob_rd_d = err_oob_rd_q;
      end
    end else begin
      rd_oob_d = rd_oob_q;
    end

    // A write in the cycle processing_done is seen still commits, since state_q is SERVE.
    if (wr_req_s) begin
      if (wr_hit_s) begin
        out_buf_d[wr_off_s[DW-1:0]] = bus.mem_data_out;
      end else begin
        err_bad_wr_d = 1'b1;
      end
    end else begin
      err_bad_wr_d = err_bad_wr_q;
    end

    case (state_q)
      LOAD: begin
        if (load_fire_s) begin
          if (load_idx_q == LW'(NPIX - 1)) begin
            state_d = SERVE;
          end else begin
            load_idx_d = load_idx_q + LW'(1);
          end
        end else begin
          load_idx_d = load_idx_q;
        end
      end
      SERVE: begin
        if (bus.processing_done) begin
          state_d = DRAIN;
        end else begin
          state_d = SERVE;
        end
      end
      DRAIN: begin
        if (drain_fire_s) begin
          if (drain_idx_q == DW'(NOUT - 1)) begin
            state_d = DONE;
          end else begin
            drain_idx_d = drain_idx_q + DW'(1);
          end
        end else begin
          drain_idx_d = drain_idx_q;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    load_ready_d  = (state_d == LOAD);
    image_ready_d = (state_d != LOAD);
    rd_valid_d    = (state_d == DRAIN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LOAD;
      load_idx_q    <= {LW{1'b0}};
      drain_idx_q   <= {DW{1'b0}};
      for (int i = 0; i < int'(NOUT); i++) begin
        out_buf_q[i] <= 8'h00;
      end
      rd_oob_q      <= 1'b0;
      err_oob_rd_q  <= 1'b0;
      err_bad_wr_q  <= 1'b0;
      load_ready_q  <= 1'b1;
      image_ready_q <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_idx_q    <= load_idx_d;
      drain_idx_q   <= drain_idx_d;
      out_buf_q     <= out_buf_d;
      rd_oob_q      <= rd_oob_d;
      err_oob_rd_q  <= err_oob_rd_d;
      err_bad_wr_q  <= err_bad_wr_d;
      load_ready_q  <= load_ready_d;
      image_ready_q <= image_ready_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign bus.mem_data_in = rd_oob_q ? OOB_DATA : ram_rdata_s;
  assign bus.load_ready  = load_ready_q;
  assign bus.image_ready = image_ready_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = out_buf_q[drain_idx_q];
  assign bus.err_oob_rd  = err_oob_rd_q;
  assign bus.err_bad_wr  = err_bad_wr_q;

endmodule

// File: tb/tb_otsu_mem_responder.sv
// Directed bench for otsu_mem_responder with a per-cycle behavioural reference model.
module tb_otsu_mem_responder;

  localparam int          NPIX = 64;
  localparam int          NOUT = 8;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;

  otsu_mem_responder_if bus();

  otsu_mem_responder #(
    .IMAGE_WIDTH  (8),
    .IMAGE_HEIGHT (8),
    .OUT_BASE     (32'h0010_0000),
    .OOB_DATA     (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 load, 1 serve, 2 drain, 3 done.
  int         m_ph   = 0;
  int         m_lcnt = 0;
  int         m_dcnt = 0;
  logic [7:0] m_pix [NPIX];
  logic [7:0] m_out [NOUT];
  logic [7:0] m_rdat = 8'h00;
  bit         m_eo = 1'b0;
  bit         m_ew = 1'b0;
  int         m_nph;
  longint     m_a;

  always @(posedge clk) begin
    if (reset) begin
      m_ph = 0; m_lcnt = 0; m_dcnt = 0; m_rdat = 8'h00; m_eo = 1'b0; m_ew = 1'b0;
      for (int i = 0; i < NOUT; i++) m_out[i] = 8'h00;
    end else begin
      m_nph = m_ph;
      m_a   = longint'(bus.mem_addr);
      if (bus.mem_en && !bus.mem_rw) begin
        if (m_ph != 0 && m_a < NPIX) m_rdat = m_pix[int'(m_a)];
        else begin m_rdat = 8'hFF; m_eo = 1'b1; end
      end
      if (bus.mem_en && bus.mem_rw) begin
        if (m_ph == 1 && m_a >= longint'(BASE) && m_a < longint'(BASE) + NOUT)
          m_out[int'(m_a - longint'(BASE))] = bus.mem_data_out;
        else m_ew = 1'b1;
      end
      if (m_ph == 0 && bus.load_valid) begin
        m_pix[m_lcnt] = bus.load_data;
        m_lcnt++;
        if (m_lcnt == NPIX) m_nph = 1;
      end else if (m_ph == 1 && bus.processing_done) begin
        m_nph = 2;
      end else if (m_ph == 2 && bus.rd_ready) begin
        m_dcnt++;
        if (m_dcnt == NOUT) m_nph = 3;
      end
      m_ph = m_nph;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_data_in", bus.mem_data_in, m_rdat);
      chk("load_ready", {7'd0, bus.load_ready}, {7'd0, m_ph == 0});
      chk("image_ready", {7'd0, bus.image_ready}, {7'd0, m_ph != 0});
      chk("rd_valid", {7'd0, bus.rd_valid}, {7'd0, m_ph == 2});
      chk("err_oob_rd", {7'd0, bus.err_oob_rd}, {7'd0, m_eo});
      chk("err_bad_wr", {7'd0, bus.err_bad_wr}, {7'd0, m_ew});
      if (m_ph == 2) chk("rd_data", bus.rd_data, m_out[m_dcnt]);
      else if (m_ph < 2) chk("rd_data_idle", bus.rd_data, m_out[0]);
    end
  end

  logic [7:0] got_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic load_image();
    int i = 0;
    int c = 0;
    while (i < NPIX && c < 200) begin
      bus.load_valid = (c % 5 != 4);
      bus.load_data  = (i % 8 < 4) ? 8'h3F : 8'hC0;
      tick();
      if (bus.load_valid) i++;
      c++;
    end
    bus.load_valid = 1'b0;
    chk("image_ready_after_load", {7'd0, bus.image_ready}, 8'h01);
    chk("load_ready_after_load", {7'd0, bus.load_ready}, 8'h00);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] exp);
    bus.mem_en = 1'b1; bus.mem_rw = 1'b0; bus.mem_addr = addr;
    tick();
    bus.mem_en = 1'b0;
    chk($sformatf("rd_%08h", addr), bus.mem_data_in, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] data);
    bus.mem_en = 1'b1; bus.mem_rw = 1'b1; bus.mem_addr = addr; bus.mem_data_out = data;
    tick();
    bus.mem_en = 1'b0; bus.mem_rw = 1'b0;
  endtask

  task automatic drain(input int nbytes, input bit toggle);
    int budget = 0;
    got_q.delete();
    bus.rd_ready = 1'b1;
    while (got_q.size() < nbytes && budget < 60) begin
      if (bus.rd_valid && bus.rd_ready) got_q.push_back(bus.rd_data);
      tick();
      if (toggle) bus.rd_ready = ~bus.rd_ready;
      budget++;
    end
    if (got_q.size() < nbytes) chk("drain_timeout", 8'(got_q.size()), 8'(nbytes));
  endtask

  task automatic check_drained(input string tag, input logic [7:0] exp [NOUT]);
    for (int i = 0; i < NOUT; i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp[i]);
  endtask

  logic [7:0] exp_a [NOUT];
  logic [7:0] exp_b [NOUT];

  initial begin
    exp_a = '{8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA};
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    bus.mem_en = 1'b0; bus.mem_rw = 1'b0; bus.mem_addr = 32'h0; bus.mem_data_out = 8'h00;
    bus.processing_done = 1'b0; bus.load_valid = 1'b0; bus.load_data = 8'h00; bus.rd_ready = 1'b0;

    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    chk("rst_mem_data_in", bus.mem_data_in, 8'h00);
    chk("rst_load_ready", {7'd0, bus.load_ready}, 8'h01);
    chk("rst_image_ready", {7'd0, bus.image_ready}, 8'h00);
    chk("rst_rd_valid", {7'd0, bus.rd_valid}, 8'h00);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_err_oob_rd", {7'd0, bus.err_oob_rd}, 8'h00);
    chk("rst_err_bad_wr", {7'd0, bus.err_bad_wr}, 8'h00);
    reset = 1'b0;

    // Run 1: load, reads, error cases, writes and a throttled drain.
    load_image();
    rd(32'd0, 8'h3F);
    rd(32'd4, 8'hC0);
    rd(32'd63, 8'hC0);
    rd(32'd64, 8'hFF);
    chk("err_oob_after_64", {7'd0, bus.err_oob_rd}, 8'h01);
    wr(32'h0010_0008, 8'h11);
    wr(32'h000F_FFFF, 8'h22);
    chk("err_bad_wr_after_drops", {7'd0, bus.err_bad_wr}, 8'h01);
    wr(BASE, 8'hF0);
    wr(BASE + 32'd7, 8'h0F);
    wr(BASE + 32'd7, 8'hAA);
    bus.processing_done = 1'b1;
    tick();
    bus.processing_done = 1'b0;
    chk("rd_valid_after_done", {7'd0, bus.rd_valid}, 8'h01);
    drain(NOUT, 1'b1);
    bus.rd_ready = 1'b0;
    check_drained("drain1", exp_a);
    chk("rd_valid_after_drain", {7'd0, bus.rd_valid}, 8'h00);
    rd(32'd5, 8'hC0);

    // Run 2: write committed in the same cycle as processing_done.
    do_reset(2);
    load_image();
    bus.mem_en = 1'b1; bus.mem_rw = 1'b1; bus.mem_addr = BASE + 32'd3; bus.mem_data_out = 8'h5A;
    bus.processing_done = 1'b1;
    tick();
    bus.mem_en = 1'b0; bus.mem_rw = 1'b0; bus.processing_done = 1'b0;
    drain(NOUT, 1'b0);
    bus.rd_ready = 1'b0;
    check_drained("drain2", exp_b);
    chk("err_bad_wr_run2", {7'd0, bus.err_bad_wr}, 8'h00);

    // Run 3: abandon a drain with reset after three bytes.
    do_reset(2);
    load_image();
    rd(32'd100, 8'hFF);
    wr(BASE + 32'd1, 8'h77);
    wr(BASE + 32'd9, 8'h33);
    bus.processing_done = 1'b1;
    tick();
    bus.processing_done = 1'b0;
    drain(3, 1'b0);
    chk("mid_drain_byte1", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'h77);
    reset = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("mid_rst_load_ready", {7'd0, bus.load_ready}, 8'h01);
    chk("mid_rst_rd_valid", {7'd0, bus.rd_valid}, 8'h00);
    chk("mid_rst_rd_data", bus.rd_data, 8'h00);
    chk("mid_rst_err_oob_rd", {7'd0, bus.err_oob_rd}, 8'h00);
    chk("mid_rst_err_bad_wr", {7'd0, bus.err_bad_wr}, 8'h00);
    chk("mid_rst_image_ready", {7'd0, bus.image_ready}, 8'h00);
    reset = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/otsu_mem_responder.md
# otsu_mem_responder

Synthesizable memory responder for the `otsu_top` memory initiator port. It holds the input image and answers pixel reads with one-cycle latency. It captures the packed binary output bytes written to the output window. After `processing_done`, it streams those bytes out over a valid/ready port. A host preloads the image through a separate valid/ready load port, and bench and FPGA wrappers place this block beside `otsu_top`.

## Interface
Parameters:
- `IMAGE_WIDTH`, 8: pixels per row.
- `IMAGE_HEIGHT`, 8: rows. `NPIX = IMAGE_WIDTH*IMAGE_HEIGHT` must be a multiple of 8.
- `OUT_BASE`, 32'h0010_0000: first byte address of the output window. `NOUT = NPIX/8` bytes.
- `OOB_DATA`, 8'hFF: data returned on an out-of-range read.

Ports (one clock domain; `reset` is synchronous, active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous active-high reset
- `mem_en`  in  1  access strobe from `otsu_top`
- `mem_rw`  in  1  0 = read, 1 = write
- `mem_addr`  in  32  byte address
- `mem_data_out`  in  8  write data from `otsu_top`
- `mem_data_in`  out  8  registered read data to `otsu_top`
- `processing_done`  in  1  end-of-processing indication from `otsu_top`
- `load_valid`  in  1  host pixel valid
- `load_data`  in  8  host pixel, raster order
- `load_ready`  out  1  high in LOAD
- `image_ready`  out  1  high once all `NPIX` pixels are loaded
- `rd_valid`  out  1  drain byte valid
- `rd_data`  out  8  drain byte, `out_buf[drain_idx]`
- `rd_ready`  in  1  drain consumer ready
- `err_oob_rd`  out  1  sticky: an out-of-range or premature read occurred
- `err_bad_wr`  out  1  sticky: a write fell outside the output window, or arrived outside SERVE

## Operation
- FSM states are LOAD, SERVE, DRAIN and DONE. Reset enters LOAD.
- **LOAD**
  - `load_ready=1`. A beat transfers when `load_valid && load_ready`. It writes `pix[load_idx]` and then increments `load_idx`.
  - Accepting pixel `NPIX-1` moves the FSM to SERVE.
  - `processing_done` is ignored in LOAD.
- **SERVE**
  - Read (`mem_en && !mem_rw`):
    - If `mem_addr < NPIX`, return `pix[mem_addr]`.
    - Otherwise return `OOB_DATA` and set `err_oob_rd`.
  - Write (`mem_en && mem_rw`):
    - If `OUT_BASE <= mem_addr < OUT_BASE+NOUT`, store `out_buf[mem_addr-OUT_BASE] = mem_data_out`. The last write to an address wins.
    - Otherwise drop the write and set `err_bad_wr`.
  - `processing_done==1` moves the FSM to DRAIN. A write in that same cycle is committed first.
- **DRAIN**
  - `rd_valid=1`, `rd_data=out_buf[drain_idx]`, with `drain_idx` starting at 0.
  - A byte transfers on `rd_valid && rd_ready`, then `drain_idx` increments.
  - The transfer of byte `NOUT-1` moves the FSM to DONE.
  - Reads are still served. Writes are dropped and set `err_bad_wr`.
- **DONE**
  - `rd_valid=0`. Reads are still served, writes are dropped and flagged.
  - The block holds here until `reset`.
- **Any access in LOAD**
  - A read returns `OOB_DATA` and sets `err_oob_rd`.
  - A write is dropped and sets `err_bad_wr`.
- **Address compares** use the full 32-bit unsigned `mem_addr`. No address aliasing.
- **Index widths:** `$clog2(NPIX)` for `load_idx`, `$clog2(NOUT)` (minimum 1) for `drain_idx`. Neither index wraps: each FSM transition fires exactly at the last index.

## Timing
- **Reset values:**
  - `mem_data_in=0`, `load_ready=1`, `image_ready=0`, `rd_valid=0`.
  - `rd_data=0`, because `out_buf` is cleared to zero on reset.
  - `err_oob_rd=0`, `err_bad_wr=0`.
  - `pix` contents need not be cleared.
- **Read latency:** exactly 1 cycle. `mem_data_in` updates at the edge sampling the read and holds its value until the next read.
- **Writes** commit at the sampling edge. A read of `out_buf` through the drain port sees the write from the next cycle.
- **Output flag timing:**
  - `image_ready` rises in the cycle after the last load beat. `load_ready` falls in that same cycle.
  - `rd_valid` rises in the cycle after `processing_done` is sampled in SERVE.
  - `rd_data` must stay stable while `rd_valid && !rd_ready`.
- **Sticky errors** assert in the cycle after the offending access and clear only on reset.
- **Reset mid-operation:** `reset` in any state returns all registers to their reset values in the next cycle. Any partial load or drain is abandoned.

## Structure
- Package `otsu_pkg` holds:
  - the `otsu_mem_state_t` enum (LOAD, SERVE, DRAIN, DONE);
  - the `OTSU_OUT_BASE` and `OTSU_OOB_DATA` constants;
  - an `otsu_nout(w,h)` function.
- One sub-module, `otsu_pix_ram`: `NPIX`×8 storage with one synchronous write port (load) and one registered read port (mem). The FSM, `out_buf` register array, address decode and flags live in the top.

## Test plan
- **Reset:** hold `reset` for 3 cycles → `mem_data_in=00`, `load_ready=1`, `image_ready=0`, `rd_valid=0`, both error flags 0.
- **Load:** load 64 pixels of `(i%8<4)?3F:C0` with a `load_valid` gap every 5th cycle → `image_ready=1` one cycle after the 64th beat.
  - Then read addresses 0, 4 and 63 → `3F`, `C0`, `C0`, each one cycle after its request.
- **Errors:** read address 64 → `FF` with `err_oob_rd=1`.
  - Write `0x0010_0008` and write `0x000F_FFFF` → both dropped, `err_bad_wr=1`, `out_buf` unchanged.
- **Write and drain:**
  - Write `0x0010_0000=F0`, then `0x0010_0007=0F`, then `0x0010_0007=AA`.
  - Pulse `processing_done` and toggle `rd_ready` every cycle → drained bytes are `F0,00,00,00,00,00,00,AA`, then `rd_valid=0`.
- **Simultaneous write and done:** write `0x0010_0003=5A` in the same cycle as `processing_done` → byte 3 drains as `5A`.
- **Reset mid-drain:** assert `reset` after 3 drained bytes → next cycle `load_ready=1`, `rd_valid=0`, `rd_data=00`, flags cleared.
